// File: rtl/param_mux_pkg.sv
// Shared constants and helpers for the parametrised channel multiplexer.
package param_mux_pkg;

  // Selection modes
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2 that never returns 0, so a select field is always at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    for (r = 1; (64'd1 << r) < 64'(n); r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority finder: returns the first set request at or after start,
// wrapping from NUM_CH-1 back to 0. Never produces an index >= NUM_CH.
module rr_pick
  import param_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  // One extra bit so start + offset cannot overflow before the explicit wrap.
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [SEL_W-1:0] base;
  logic [SEL_W:0]   pos;

  // Walk the channels in cyclic order and latch the first requester.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    base  = ({1'b0, start} < NUM_CH_W) ? start : '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pos = {1'b0, base} + (SEL_W + 1)'(k);
      if (pos >= NUM_CH_W) begin
        pos = pos - NUM_CH_W;
      end
      if (!found && req[pos[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/param_mux_seq.sv
// Registered NUM_CH-to-1 channel multiplexer with manual and round-robin scan selection,
// presenting the selected channel as a valid/ready stream.
module param_mux_seq
  import param_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     skip_idle,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [DATA_W-1:0] ch_arr [NUM_CH];
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              capture;
  logic              load;

  // Unpack the flat channel bus into an indexable array.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req   (ch_valid),
    .start (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The output register is free when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // Choose the candidate channel and decide whether it can be captured.
  always_comb begin
    cand    = ptr_q;
    capture = 1'b0;
    if (mode == MODE_MANUAL) begin
      cand    = sel_in;
      // Out-of-range selects (non-power-of-2 NUM_CH) are never captured.
      capture = ({1'b0, sel_in} < NUM_CH_W) && ch_valid[sel_in];
    end else if (!skip_idle) begin
      capture = ch_valid[ptr_q];
    end else begin
      cand    = pick_idx;
      capture = pick_found;
    end
  end

  // Advance the scan pointer past the captured channel, wrapping explicitly.
  always_comb begin
    ptr_d = ptr_q;
    if (load && capture && (mode == MODE_SCAN)) begin
      ptr_d = (cand == LAST_CH) ? '0 : cand + SEL_W'(1);
    end
  end

  // Scan pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Output stage: capture on load, otherwise hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      if (capture) begin
        out_data  <= ch_arr[cand];
        out_ch    <= cand;
        out_valid <= 1'b1;
        out_last  <= (mode == MODE_SCAN) && (cand == LAST_CH);
      end else begin
        // Data and channel keep their stale values; only the qualifiers drop.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_mux_seq.sv
// Self-checking bench: an 8-channel and a 5-channel instance share stimulus and are each
// compared every cycle against a behavioural model, plus directed literal expectations.
module tb_param_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] ch_data;
  logic [7:0]  ch_valid;
  logic        mode;
  logic [2:0]  sel_in;
  logic        skip_idle;
  logic        out_ready;

  logic [7:0]  o8_data, o5_data;
  logic [2:0]  o8_ch, o5_ch;
  logic        o8_valid, o5_valid, o8_last, o5_last;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int   ptr;
    int   data;
    int   ch;
    logic valid;
    logic last;
  } mstate_t;

  mstate_t m8 = '0;
  mstate_t m5 = '0;

  always #5 clk = ~clk;

  param_mux_seq #(.NUM_CH(8), .DATA_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .mode      (mode),
    .sel_in    (sel_in),
    .skip_idle (skip_idle),
    .out_data  (o8_data),
    .out_ch    (o8_ch),
    .out_valid (o8_valid),
    .out_ready (out_ready),
    .out_last  (o8_last)
  );

  param_mux_seq #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data   (ch_data[39:0]),
    .ch_valid  (ch_valid[4:0]),
    .mode      (mode),
    .sel_in    (sel_in),
    .skip_idle (skip_idle),
    .out_data  (o5_data),
    .out_ch    (o5_ch),
    .out_valid (o5_valid),
    .out_ready (out_ready),
    .out_last  (o5_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One transfer slot of the reference behaviour for an n-channel instance.
  function automatic mstate_t model_step(input mstate_t s, input int n, input logic [63:0] d,
                                         input logic [7:0] v, input logic md,
                                         input logic [2:0] sel, input logic sk,
                                         input logic rdy);
    mstate_t r;
    int      cand;
    int      j;
    r    = s;
    cand = -1;
    if (s.valid && !rdy) return r;
    if (!md) begin
      if (int'(sel) < n && ((v >> sel) & 8'd1) != 8'd0) cand = int'(sel);
    end else if (!sk) begin
      if (((v >> s.ptr) & 8'd1) != 8'd0) cand = s.ptr;
    end else begin
      for (int k = 0; k < n; k++) begin
        j = (s.ptr + k) % n;
        if (cand < 0 && ((v >> j) & 8'd1) != 8'd0) cand = j;
      end
    end
    if (cand >= 0) begin
      r.data  = 32'((d >> (cand * 8)) & 64'hff);
      r.ch    = cand;
      r.valid = 1'b1;
      r.last  = md && (cand == n - 1);
      if (md) r.ptr = (cand + 1) % n;
    end else begin
      r.valid = 1'b0;
      r.last  = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '0;
      m5 <= '0;
    end else begin
      m8 <= model_step(m8, 8, ch_data, ch_valid, mode, sel_in, skip_idle, out_ready);
      m5 <= model_step(m5, 5, {24'b0, ch_data[39:0]}, {3'b0, ch_valid[4:0]}, mode, sel_in,
                       skip_idle, out_ready);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("n8 out_data", 32'(o8_data), m8.data);
    check("n8 out_ch", 32'(o8_ch), m8.ch);
    check("n8 out_valid", 32'(o8_valid), 32'(m8.valid));
    check("n8 out_last", 32'(o8_last), 32'(m8.last));
    check("n5 out_data", 32'(o5_data), m5.data);
    check("n5 out_ch", 32'(o5_ch), m5.ch);
    check("n5 out_valid", 32'(o5_valid), 32'(m5.valid));
    check("n5 out_last", 32'(o5_last), 32'(m5.last));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic init_data();
    for (int i = 0; i < 8; i++) ch_data[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  task automatic exp8(input string name, input int ch, input logic valid, input logic last);
    check({name, " ch"}, 32'(o8_ch), ch);
    check({name, " valid"}, 32'(o8_valid), 32'(valid));
    check({name, " last"}, 32'(o8_last), 32'(last));
    if (valid) check({name, " data"}, 32'(o8_data), 32'h10 + ch);
  endtask

  initial begin
    int seq3 [7] = '{0, 2, 7, 0, 2, 7, 0};
    int seq5 [6] = '{5, 6, 7, 0, 1, 2};
    init_data();
    ch_valid  = 8'hff;
    mode      = 1'b0;
    sel_in    = 3'd5;
    skip_idle = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, then manual select of channel 5.
    tick();
    exp8("reset", 0, 1'b0, 1'b0);
    check("reset data", 32'(o8_data), 32'h0);
    rst_n = 1'b1;
    tick();
    exp8("manual sel5", 5, 1'b1, 1'b0);
    check("model manual data", m8.data, 32'h15);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async data", 32'(o8_data), 32'h0);
    check("async ch", 32'(o8_ch), 32'h0);
    check("async valid", 32'(o8_valid), 32'h0);
    check("async last", 32'(o8_last), 32'h0);
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;

    // Scan sweep, no skipping, two full rounds.
    for (int k = 0; k < 16; k++) begin
      tick();
      exp8("sweep", k % 8, 1'b1, (k % 8) == 7);
    end
    ch_valid  = 8'b1000_0101;
    skip_idle = 1'b1;

    // Skip idle channels: no bubbles between valid ones.
    for (int k = 0; k < 7; k++) begin
      tick();
      exp8("skip", seq3[k], 1'b1, seq3[k] == 7);
    end
    skip_idle = 1'b0;
    tick();
    exp8("wait idle", 0, 1'b0, 1'b0);
    tick();
    exp8("wait idle2", 0, 1'b0, 1'b0);
    check("model ptr held", m8.ptr, 1);
    ch_valid = 8'b1000_0111;
    tick();
    exp8("wait resolved", 1, 1'b1, 1'b0);
    ch_valid = 8'hff;

    // Backpressure holds the captured transfer; inputs changed during the stall are ignored.
    tick();
    exp8("bp pre", 2, 1'b1, 1'b0);
    tick();
    exp8("bp cap", 3, 1'b1, 1'b0);
    out_ready        = 1'b0;
    ch_data[31:24]   = 8'haa;
    ch_valid         = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp8("bp stall", 3, 1'b1, 1'b0);
      check("model ptr stall", m8.ptr, 4);
    end
    out_ready = 1'b1;
    ch_valid  = 8'hff;
    init_data();
    tick();
    exp8("bp release", 4, 1'b1, 1'b0);

    // Mode switch: manual excursion does not disturb the scan pointer.
    for (int k = 0; k < 6; k++) begin
      tick();
      exp8("pre switch", seq5[k], 1'b1, seq5[k] == 7);
    end
    mode   = 1'b0;
    sel_in = 3'd6;
    tick();
    exp8("manual6 a", 6, 1'b1, 1'b0);
    tick();
    exp8("manual6 b", 6, 1'b1, 1'b0);
    mode = 1'b1;
    tick();
    exp8("scan resume", 3, 1'b1, 1'b0);

    // Non-power-of-2 instance: scan wraps at 4, illegal select yields no transfer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("n5 sweep ch", 32'(o5_ch), k % 5);
      check("n5 sweep last", 32'(o5_last), 32'((k % 5) == 4));
    end
    mode   = 1'b0;
    sel_in = 3'd6;
    tick();
    check("n5 illegal valid", 32'(o5_valid), 32'h0);
    check("n8 sel6 ch", 32'(o8_ch), 32'd6);

    // Randomised traffic; the per-cycle compare carries the checking.
    for (int k = 0; k < 2000; k++) begin
      tick();
      ch_data   = {$urandom, $urandom};
      ch_valid  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom) | 8'($urandom);
      if ($urandom_range(9) == 0) mode = ~mode;
      sel_in    = 3'($urandom);
      skip_idle = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(199) != 0);
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
